// File: rtl/mem_load_queue.sv
// -----------------------------------------------------------------------------
// mem_load_queue
//   Tracks outstanding data-SRAM requests in issue order. Each response is
//   paired with its request, aligned and extended by load type, and presented
//   to the write-back side one entry at a time. A flush cancels everything in
//   flight. Responses that were already owed to the SRAM are then counted in
//   cancel_cnt and dropped as they come back.
//
// Parameters
//   DEPTH       maximum outstanding requests (power of 2, 2..16)
//   TAG_W       width of the per-request tag
//
// Ports
//   clk         clock, rising edge
//   reset       synchronous, active-high reset
//   req_fire    request accepted by the SRAM this cycle
//   req_store   accepted request is a store (response carries no data)
//   req_op      one-hot load type {ld_b, ld_h, ld_w, ld_bu, ld_hu}
//   req_lowbits address bits [1:0] of the request
//   req_tag     tag returned with the response
//   data_ok     SRAM response strobe (in request order)
//   rdata       SRAM read data, valid with data_ok
//   flush       cancels all requests in flight
//   full        no further request may be issued this cycle
//   out_valid   head response is complete and presented
//   out_ready   consumer accepts the head
//   out_data    aligned/extended load result, 0 for stores
//   out_tag     tag of the head entry
//   out_store   head entry is a store acknowledgement
//   err         sticky protocol error flag
//
// Configuration
//   MEM_LOADQ_BYPASS_EN  when defined, a non-cancelled response for the head
//                        entry is presented in the same cycle as data_ok.
//                        It is not stored if it is accepted in that cycle.
// -----------------------------------------------------------------------------
module mem_load_queue #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_fire,
   input  logic             req_store,
   input  logic [4:0]       req_op,
   input  logic [1:0]       req_lowbits,
   input  logic [TAG_W-1:0] req_tag,
   input  logic             data_ok,
   input  logic [31:0]      rdata,
   input  logic             flush,
   output logic             full,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_store,
   output logic             err
);

   localparam int PW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit so a full queue differs from an empty one.
   // cancel_cnt shares this type because it never exceeds DEPTH.
   typedef logic [PW:0] ptr_t;
   localparam ptr_t ONE = ptr_t'(1);

   typedef struct packed {
      logic             store;
      logic [4:0]       op;
      logic [1:0]       lowbits;
      logic [TAG_W-1:0] tag;
   } meta_t;

   ptr_t        wr, rsp, rd, cancel_cnt;
   meta_t       meta_q [DEPTH];
   logic [31:0] data_q [DEPTH];

   ptr_t        occupied, pending;
   logic        fire_ok, drop, rsp_ok, rsp_bad, head_done, bypass;
   meta_t       head;
   logic [31:0] head_raw;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign occupied = wr - rd;
   assign pending  = wr - rsp;
   assign full     = (occupied + cancel_cnt) == ptr_t'(DEPTH);

   assign fire_ok  = req_fire && !full;
   assign drop     = data_ok && (cancel_cnt != '0);
   assign rsp_ok   = data_ok && (cancel_cnt == '0) && (pending != '0);
   assign rsp_bad  = data_ok && (cancel_cnt == '0) && (pending == '0);

   // Entries in [rd, rsp) are done. The done bits are held implicitly by the pointers.
   assign head_done = (rd != rsp);

`ifdef MEM_LOADQ_BYPASS_EN
   // With no done entry ahead, a good response belongs to the head itself.
   // A data_ok in the flush cycle is cancelled along with its request.
   assign bypass = rsp_ok && !head_done && !flush;
`else
   assign bypass = 1'b0;
`endif

   assign out_valid = head_done || bypass;
   assign head      = meta_q[rd[PW-1:0]];
   assign head_raw  = bypass ? rdata : data_q[rd[PW-1:0]];
   assign out_tag   = head.tag;
   assign out_store = head.store;

   always_comb begin
      // NOTE: every signal written here is given a default first, so no latch is inferred.
      byte_sel = head_raw[7:0];
      case (head.lowbits)
         2'd0: byte_sel = head_raw[7:0];
         2'd1: byte_sel = head_raw[15:8];
         2'd2: byte_sel = head_raw[23:16];
         2'd3: byte_sel = head_raw[31:24];
      endcase
      half_sel = head.lowbits[1] ? head_raw[31:16] : head_raw[15:0];

      out_data = head_raw;
      if (head.store)       out_data = '0;
      else if (head.op[4])  out_data = {{24{byte_sel[7]}}, byte_sel};
      else if (head.op[1])  out_data = {24'b0, byte_sel};
      else if (head.op[3])  out_data = {{16{half_sel[15]}}, half_sel};
      else if (head.op[0])  out_data = {16'b0, half_sel};
   end

   // Pointers, cancel count and error flag.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         wr         <= '0;
         rsp        <= '0;
         rd         <= '0;
         cancel_cnt <= '0;
         err        <= 1'b0;
      end else begin
         if ((req_fire && full) || rsp_bad)
            err <= 1'b1;

         if (flush) begin
            // A request fired in this cycle is cancelled and is never written.
            // Every response still owed to the SRAM is counted in cancel_cnt.
            rsp        <= wr;
            rd         <= wr;
            cancel_cnt <= pending + cancel_cnt - ptr_t'(drop || rsp_ok) + ptr_t'(fire_ok);
         end else begin
            if (fire_ok)                wr         <= wr + ONE;
            if (rsp_ok)                 rsp        <= rsp + ONE;
            if (drop)                   cancel_cnt <= cancel_cnt - ONE;
            if (out_valid && out_ready) rd         <= rd + ONE;
         end
      end
   end

   // Entry storage.
   always_ff @(posedge clk) begin
      // NOTE: the storage arrays are not reset; the pointers alone decide which entries are live.
      if (fire_ok && !flush && !reset)
         meta_q[wr[PW-1:0]] <= '{store: req_store, op: req_op, lowbits: req_lowbits, tag: req_tag};
      if (rsp_ok && !flush && !reset && !(bypass && out_ready))
         data_q[rsp[PW-1:0]] <= rdata;
   end

endmodule

// File: tb/tb_mem_load_queue.sv
// -----------------------------------------------------------------------------
// tb_mem_load_queue
//   Self-checking bench for mem_load_queue (DEPTH=4, TAG_W=5). It covers
//   formatting vectors, hand-written corner sequences, and a randomized run
//   against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_mem_load_queue;

   localparam int DEPTH = 4;
   localparam int TAG_W = 5;
`ifdef MEM_LOADQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   localparam logic [4:0] LD_B  = 5'b10000;
   localparam logic [4:0] LD_H  = 5'b01000;
   localparam logic [4:0] LD_W  = 5'b00100;
   localparam logic [4:0] LD_BU = 5'b00010;
   localparam logic [4:0] LD_HU = 5'b00001;

   logic             clk = 1'b0;
   logic             reset;
   logic             req_fire, req_store;
   logic [4:0]       req_op;
   logic [1:0]       req_lowbits;
   logic [TAG_W-1:0] req_tag;
   logic             data_ok;
   logic [31:0]      rdata;
   logic             flush;
   logic             full, out_valid, out_ready, out_store, err;
   logic [31:0]      out_data;
   logic [TAG_W-1:0] out_tag;

   int n_checks = 0;
   int n_fail   = 0;

   mem_load_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .reset(reset), .req_fire(req_fire), .req_store(req_store),
      .req_op(req_op), .req_lowbits(req_lowbits), .req_tag(req_tag),
      .data_ok(data_ok), .rdata(rdata), .flush(flush), .full(full),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_tag(out_tag), .out_store(out_store), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      req_fire = 0; req_store = 0; req_op = LD_W; req_lowbits = 0; req_tag = '0;
      data_ok = 0; rdata = '0; flush = 0; out_ready = 0;
   endtask

   // Inputs change 1 time unit after the rising edge and are sampled 1 unit later.
   task automatic step();
      @(posedge clk); #1;
      idle(); #1;
   endtask

   task automatic do_fire(input logic st, input logic [4:0] op, input logic [1:0] lb,
                          input logic [TAG_W-1:0] tag);
      req_fire = 1; req_store = st; req_op = op; req_lowbits = lb; req_tag = tag;
      step();
   endtask

   task automatic do_rsp(input logic [31:0] d);
      data_ok = 1; rdata = d;
      step();
   endtask

   task automatic do_reset();
      reset = 1; idle();
      step(); step();
      reset = 0;
   endtask

   // Reference formatting, computed with shifts and masks.
   function automatic logic [31:0] fmt(input logic st, input logic [4:0] op,
                                       input logic [1:0] lb, input logic [31:0] d);
      logic [31:0] b, h;
      b = (d >> (8 * lb)) & 32'hFF;
      h = (d >> (16 * lb[1])) & 32'hFFFF;
      if (st) return 32'h0;
      case (op)
         LD_B:    return (b >= 32'd128)   ? b - 32'd256   : b;
         LD_H:    return (h >= 32'd32768) ? h - 32'd65536 : h;
         LD_BU:   return b;
         LD_HU:   return h;
         default: return d;
      endcase
   endfunction

   typedef struct {
      logic        store;
      logic [4:0]  op;
      logic [1:0]  lb;
      logic [31:0] rdata;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[8];

   typedef struct {
      logic             store;
      logic [4:0]       op;
      logic [1:0]       lb;
      logic [TAG_W-1:0] tag;
      logic             done;
      logic [31:0]      data;
   } ent_t;
   ent_t mq[$];
   int   m_cancel;
   logic m_err;

   initial begin
      vecs[0] = '{1'b0, LD_B,  2'd3, 32'h80FF_0000, 32'hFFFF_FF80};
      vecs[1] = '{1'b0, LD_BU, 2'd3, 32'h80FF_0000, 32'h0000_0080};
      vecs[2] = '{1'b0, LD_H,  2'd2, 32'h80FF_0000, 32'hFFFF_80FF};
      vecs[3] = '{1'b0, LD_HU, 2'd0, 32'h1234_F00D, 32'h0000_F00D};
      vecs[4] = '{1'b0, LD_W,  2'd0, 32'h1234_5678, 32'h1234_5678};
      vecs[5] = '{1'b0, LD_B,  2'd1, 32'h0000_7F00, 32'h0000_007F};
      vecs[6] = '{1'b0, LD_H,  2'd0, 32'h0000_7FFE, 32'h0000_7FFE};
      vecs[7] = '{1'b1, LD_W,  2'd0, 32'hDEAD_BEEF, 32'h0000_0000};

      idle();
      do_reset();
      check("reset out_valid", out_valid, 0);
      check("reset full", full, 0);
      check("reset err", err, 0);

      // Formatting vectors; without bypass the result shows up one cycle after data_ok.
      for (int i = 0; i < 8; i++) begin
         do_fire(vecs[i].store, vecs[i].op, vecs[i].lb, TAG_W'(i + 1));
         data_ok = 1; rdata = vecs[i].rdata; #1;
         check($sformatf("vec%0d valid in data_ok cycle", i), out_valid, BYP);
         step();
         check($sformatf("vec%0d valid", i), out_valid, 1);
         check($sformatf("vec%0d data", i), out_data, vecs[i].exp);
         check($sformatf("vec%0d tag", i), out_tag, i + 1);
         check($sformatf("vec%0d store", i), out_store, vecs[i].store);
         out_ready = 1;
         step();
         check($sformatf("vec%0d drained", i), out_valid, 0);
      end

      // Four back-to-back loads fill the queue; a fifth request is an error.
      for (int i = 0; i < 4; i++) begin
         check($sformatf("fill full before load %0d", i), full, 0);
         do_fire(0, LD_W, 0, TAG_W'(i));
      end
      check("fill full after 4", full, 1);
      check("fill err before 5th", err, 0);
      do_fire(0, LD_W, 0, 5'd31);
      check("overfill err", err, 1);
      check("overfill still full", full, 1);
      step(); step();
      check("err sticky", err, 1);
      do_reset();
      check("err cleared by reset", err, 0);

      // Flush with three pending and one data_ok leaves two responses to drop.
      do_fire(0, LD_W, 0, 5'd1);
      do_fire(0, LD_W, 0, 5'd2);
      do_fire(0, LD_W, 0, 5'd3);
      flush = 1; data_ok = 1; rdata = 32'h1111_1111;
      step();
      check("flush cancel_cnt", dut.cancel_cnt, 2);
      check("flush out_valid", out_valid, 0);
      check("flush full", full, 0);
      do_rsp(32'h2222_2222);
      check("drop1 out_valid", out_valid, 0);
      check("drop1 cancel_cnt", dut.cancel_cnt, 1);
      do_rsp(32'h3333_3333);
      check("drop2 out_valid", out_valid, 0);
      check("drop2 cancel_cnt", dut.cancel_cnt, 0);
      do_fire(0, LD_W, 0, 5'd9);
      do_rsp(32'hAABB_CCDD);
      check("post-flush valid", out_valid, 1);
      check("post-flush tag", out_tag, 9);
      check("post-flush data", out_data, 32'hAABB_CCDD);
      out_ready = 1; step();
      check("post-flush drained", out_valid, 0);

      // Back-pressure: the head holds steady, then two handshakes in order.
      do_fire(0, LD_W, 0, 5'd4);
      do_fire(0, LD_HU, 2, 5'd5);
      do_rsp(32'h1111_1111);
      do_rsp(32'h2222_8001);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("stall%0d valid", i), out_valid, 1);
         check($sformatf("stall%0d data", i), out_data, 32'h1111_1111);
         check($sformatf("stall%0d tag", i), out_tag, 4);
         step();
      end
      out_ready = 1; #1;
      check("hs1 tag", out_tag, 4);
      step();
      out_ready = 1; #1;
      check("hs2 valid", out_valid, 1);
      check("hs2 tag", out_tag, 5);
      check("hs2 data", out_data, 32'h0000_2222);
      step();
      check("hs done", out_valid, 0);

      // Reset with two pending and one cancelled response outstanding.
      do_fire(0, LD_W, 0, 5'd1);
      flush = 1; step();
      do_fire(0, LD_W, 0, 5'd2);
      do_fire(0, LD_W, 0, 5'd3);
      check("pre-reset cancel_cnt", dut.cancel_cnt, 1);
      reset = 1; step(); reset = 0;
      check("mid reset out_valid", out_valid, 0);
      check("mid reset full", full, 0);
      check("mid reset err", err, 0);
      check("mid reset cancel_cnt", dut.cancel_cnt, 0);
      do_rsp(32'h5555_5555);
      check("stray data_ok err", err, 1);
      do_reset();

`ifdef MEM_LOADQ_BYPASS_EN
      do_fire(0, LD_W, 0, 5'd3);
      data_ok = 1; rdata = 32'h1234_5678; out_ready = 1; #1;
      check("bypass valid", out_valid, 1);
      check("bypass data", out_data, 32'h1234_5678);
      check("bypass tag", out_tag, 3);
      step();
      check("bypass empty valid", out_valid, 0);
      check("bypass empty ptrs", dut.wr - dut.rd, 0);
      do_reset();
`endif

      // Randomized run against the queue model.
      mq.delete(); m_cancel = 0; m_err = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         int   pend;
         bit   m_full, byp, e_valid, fire_ok;
         logic [31:0] e_data;
         pend = 0;
         foreach (mq[k]) if (!mq[k].done) pend++;
         m_full = (mq.size() + m_cancel) == DEPTH;

         req_fire    = ($urandom_range(0, 1) == 1) && !m_full;
         req_store   = ($urandom_range(0, 3) == 0);
         req_op      = 5'(1 << $urandom_range(0, 4));
         req_lowbits = 2'($urandom_range(0, 3));
         req_tag     = TAG_W'($urandom);
         data_ok     = ($urandom_range(0, 1) == 1) && (pend + m_cancel > 0);
         rdata       = $urandom;
         flush       = ($urandom_range(0, 15) == 0);
         out_ready   = ($urandom_range(0, 3) != 0);
         #1;

         byp = BYP && data_ok && !flush && m_cancel == 0 && mq.size() > 0 && !mq[0].done;
         e_valid = mq.size() > 0 && (mq[0].done || byp);
         check("rand full", full, m_full);
         check("rand err", err, m_err);
         check("rand out_valid", out_valid, e_valid);
         if (e_valid) begin
            e_data = fmt(mq[0].store, mq[0].op, mq[0].lb, byp ? rdata : mq[0].data);
            check("rand out_data", out_data, e_data);
            check("rand out_tag", out_tag, mq[0].tag);
            check("rand out_store", out_store, mq[0].store);
         end

         if ((req_fire && m_full) || (data_ok && m_cancel == 0 && pend == 0)) m_err = 1;
         fire_ok = req_fire && !m_full;
         if (flush) begin
            m_cancel = m_cancel + pend + (fire_ok ? 1 : 0)
                     - ((data_ok && (m_cancel > 0 || pend > 0)) ? 1 : 0);
            mq.delete();
         end else begin
            if (data_ok) begin
               if (m_cancel > 0) m_cancel--;
               else begin
                  for (int k = 0; k < mq.size(); k++)
                     if (!mq[k].done) begin
                        mq[k].done = 1; mq[k].data = rdata;
                        break;
                     end
               end
            end
            if (e_valid && out_ready) void'(mq.pop_front());
            if (fire_ok)
               mq.push_back('{req_store, req_op, req_lowbits, req_tag, 1'b0, 32'h0});
         end
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_load_queue.md
MEM_LOAD_QUEUE -- requirements
Module: mem_load_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the maximum number of outstanding data-SRAM requests (power of 2, 2..16).
REQ-002 The block SHALL have parameter TAG_W, default 5, meaning the width of the per-request tag (destination register).
REQ-003 The block SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port req_fire  input  1  request accepted by data SRAM this cycle (req && addr_ok).
REQ-006 The block SHALL have port req_store  input  1  accepted request is a store; its response carries no data.
REQ-007 The block SHALL have port req_op  input  5  one-hot load type {ld_b, ld_h, ld_w, ld_bu, ld_hu}.
REQ-008 The block SHALL have port req_lowbits  input  2  address bits [1:0] of the request.
REQ-009 The block SHALL have port req_tag  input  TAG_W  tag returned with the response.
REQ-010 The block SHALL have port data_ok  input  1  SRAM response strobe; responses arrive in request order.
REQ-011 The block SHALL have port rdata  input  32  SRAM read data, valid with data_ok.
REQ-012 The block SHALL have port flush  input  1  exception/ertn flush; cancels all requests in flight.
REQ-013 The block SHALL have port full  output  1  no further request may be issued this cycle.
REQ-014 The block SHALL have port out_valid  output  1  head response is complete and presented.
REQ-015 The block SHALL have port out_ready  input  1  consumer (WB side) accepts the head.
REQ-016 The block SHALL have port out_data  output  32  aligned and extended load result; 0 for stores.
REQ-017 The block SHALL have port out_tag  output  TAG_W  tag of the head entry.
REQ-018 The block SHALL have port out_store  output  1  head entry is a store acknowledgement.
REQ-019 The block SHALL have port err  output  1  sticky protocol error flag.

Function
REQ-020 The block SHALL hold DEPTH entries in a circular queue with three pointers: wr (req_fire), rsp (data_ok), rd (out_valid && out_ready), each wrapping modulo DEPTH.
REQ-021 The block SHALL store rdata into the entry at rsp and mark it done on a data_ok that is not cancelled.
REQ-022 The block SHALL format out_data as follows: ld_w -> word; ld_b/ld_bu -> byte at lowbits, sign- or zero-extended; ld_h/ld_hu -> halfword at lowbits[1], sign- or zero-extended.
REQ-023 The block SHALL assert out_valid when the head entry is done; out_data, out_tag and out_store SHALL be stable while out_valid && !out_ready.
REQ-024 The block SHALL assert full when occupied entries + cancel_cnt == DEPTH; a req_fire while full SHALL be ignored and SHALL set err.
REQ-025 The block SHALL, on flush, empty the queue (rd = rsp = wr) and set cancel_cnt = pending + cancel_cnt - (data_ok ? 1 : 0) + (req_fire ? 1 : 0), where pending = issued entries not yet responded.
REQ-026 The block SHALL, while cancel_cnt > 0, discard each data_ok and decrement cancel_cnt; cancelled responses SHALL never reach out_valid.
REQ-027 The block SHALL treat a req_fire in the flush cycle as cancelled; a req_fire in the cycle after flush SHALL be queued normally.
REQ-028 The block SHALL allow req_fire, data_ok and an output handshake in the same cycle, with each pointer advancing independently.
REQ-029 The block SHALL ignore a data_ok with no pending entry and cancel_cnt == 0, and SHALL set err.
REQ-030 The block SHALL keep err at 1 until reset.

Reset
REQ-031 The block SHALL, while reset is high, clear all pointers, cancel_cnt, done bits and err; out_valid, full and err SHALL read 0 in the cycle after reset.
REQ-032 The block SHALL give reset priority over flush, req_fire and data_ok in the same cycle.

Configuration
REQ-033 The block SHALL, when macro MEM_LOADQ_BYPASS_EN is defined, drive a non-cancelled data_ok for the head entry combinationally to out_valid and out_data in the same cycle, and SHALL not store it if out_ready is 1; without the macro, out_valid SHALL rise the cycle after data_ok.

Verification
REQ-034 Bench SHALL cover: ld_b, lowbits=2'b11, rdata=32'h80FF_0000 -> out_data=32'hFFFF_FF80 (ld_bu -> 32'h0000_0080); without bypass, out_valid one cycle after data_ok.
REQ-035 Bench SHALL cover: 4 loads issued back-to-back at DEPTH=4 -> full=1 after the 4th; a 5th req_fire sets err=1.
REQ-036 Bench SHALL cover: 3 loads pending, flush together with one data_ok -> cancel_cnt=2; the next 2 data_ok are dropped; a new load's response appears with its tag.
REQ-037 Bench SHALL cover: out_ready held 0 for 5 cycles with 2 responses done -> head data is stable, then two consecutive handshakes in order.
REQ-038 Bench SHALL cover: reset asserted with 2 pending and cancel_cnt=1 -> all zero, and a following data_ok sets err.
REQ-039 Bench SHALL cover: with MEM_LOADQ_BYPASS_EN, empty queue plus single ld_w with rdata=32'h1234_5678 and out_ready=1 -> out_valid in the data_ok cycle and the queue is empty the next cycle.
